bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.

---
 rtl/bcd_seq.sv | 147 ++++++++++++++
 tb/tb_bcd_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Results are held between conversions for the seven-segment stage.
module bcd_seq #(
    parameter int IN_WIDTH = 6,
    parameter int DIGITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [1:0]            state_dbg
);

    // Handshake: start is a request sampled only while IDLE; while busy or
    // finishing it is dropped, never queued. done pulses for one cycle and
    // bcd/ovf are valid from that cycle until the next done.

    localparam int BW    = 4 * DIGITS;
    localparam int CW    = (IN_WIDTH > BW + 1) ? IN_WIDTH : BW + 1;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    function automatic logic [CW-1:0] pow10(input int n);
        logic [CW-1:0] p;
        p = CW'(1);
        for (int i = 0; i < n; i++) begin
            p = p * CW'(10);
        end
        return p;
    endfunction

    localparam logic [CW-1:0] LIMIT = pow10(DIGITS);
    localparam logic [BW-1:0] SAT   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [IN_WIDTH-1:0]  sreg;
    logic [BW-1:0]        acc;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_next;
    logic [BW-1:0]        bcd_q;
    logic                 ovf_q;

    logic                 load;
    logic                 step;
    logic                 fin;
    logic [BW-1:0]        adj;
    logic [BW-1:0]        acc_shift;
    logic [BW-1:0]        fin_bcd;
    logic [CW-1:0]        in_ext;

    assign in_ext = CW'(in);

    // Each 4-bit lane is adjusted independently; no carry crosses lanes.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign acc_shift = {adj[BW-2:0], sreg[IN_WIDTH-1]};
    assign fin_bcd   = ovf_next ? SAT : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                fin        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (load) begin
                sreg     <= in;
                acc      <= '0;
                cnt      <= CNT_W'(IN_WIDTH);
                ovf_next <= (in_ext >= LIMIT);
            end else if (step) begin
                acc  <= acc_shift;
                sreg <= sreg << 1;
                cnt  <= cnt - CNT_W'(1);
            end
            if (fin) begin
                bcd_q <= fin_bcd;
                ovf_q <= ovf_next;
            end
        end
    end

    // The finishing value is forwarded during FIN so it is valid alongside done.
    assign bcd       = fin ? fin_bcd : bcd_q;
    assign ovf       = fin ? ovf_next : ovf_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_seq.sv
// Directed bench for bcd_seq: default, 8-bit and 1-bit input instances.
module tb_bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       start;
    logic [5:0] in;
    logic       busy, done, ovf;
    logic [7:0] bcd;
    logic [1:0] st;

    logic       start_8;
    logic [7:0] in_8;
    logic       busy_8, done_8, ovf_8;
    logic [7:0] bcd_8;
    logic [1:0] st_8;

    logic       start_1;
    logic [0:0] in_1;
    logic       busy_1, done_1, ovf_1;
    logic [7:0] bcd_1;
    logic [1:0] st_1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_bcd;
    logic [7:0] exp_q[$];

    bcd_seq #(.IN_WIDTH(6), .DIGITS(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in(in),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .state_dbg(st)
    );

    bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_w8 (
        .clk(clk), .rst(rst), .start(start_8), .in(in_8),
        .busy(busy_8), .done(done_8), .bcd(bcd_8), .ovf(ovf_8), .state_dbg(st_8)
    );

    bcd_seq #(.IN_WIDTH(1), .DIGITS(2)) u_w1 (
        .clk(clk), .rst(rst), .start(start_1), .in(in_1),
        .busy(busy_1), .done(done_1), .bcd(bcd_1), .ovf(ovf_1), .state_dbg(st_1)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; in = 6'd63;
        start_8 = 1'b1; in_8 = 8'd200; start_1 = 1'b1; in_1 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 8'h00 || ovf !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b bcd=%h ovf=%b st=%0d, want 0 0 00 0 0",
                     busy, done, bcd, ovf, st);
        end
        checks++;
        if (busy_8 !== 1'b0 || bcd_8 !== 8'h00 || busy_1 !== 1'b0 || bcd_1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_others: busy_8=%b bcd_8=%h busy_1=%b bcd_1=%h, want 0 00 0 00",
                     busy_8, bcd_8, busy_1, bcd_1);
        end
        rst = 1'b0; start = 1'b0; start_8 = 1'b0; start_1 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
        last_bcd = 8'h00;
    endtask

    task automatic conv6(input logic [5:0] v, input logic [7:0] exp_bcd);
        @(negedge clk);
        in = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in = ~v;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (k < 7) begin
                if (busy !== 1'b1 || done !== 1'b0 || bcd !== last_bcd) begin
                    errors++;
                    $display("FAIL conv_busy in=%0d cycle=%0d: busy=%b done=%b bcd=%h, want 1 0 %h",
                             v, k, busy, done, bcd, last_bcd);
                end
            end else begin
                if (done !== 1'b1 || busy !== 1'b0 || bcd !== exp_bcd || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL conv_done in=%0d: done=%b busy=%b bcd=%h ovf=%b, want 1 0 %h 0",
                             v, done, busy, bcd, ovf, exp_bcd);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bcd !== exp_bcd || st !== 2'd0) begin
            errors++;
            $display("FAIL conv_hold in=%0d: done=%b bcd=%h st=%0d, want 0 %h 0",
                     v, done, bcd, st, exp_bcd);
        end
        last_bcd = exp_bcd;
    endtask

    task automatic test_convert();
        conv6(6'd0,  8'h00);
        conv6(6'd9,  8'h09);
        conv6(6'd10, 8'h10);
        conv6(6'd63, 8'h63);
    endtask

    task automatic test_back_to_back();
        int n_done;
        int last_c;
        logic [7:0] e;
        n_done = 0;
        last_c = -1;
        repeat (3) exp_q.push_back(8'h42);
        @(negedge clk);
        in = 6'd42; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 19) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done: cycle=%0d bcd=%h, want no done", c, bcd);
                end else begin
                    e = exp_q.pop_front();
                    if (bcd !== e) begin
                        errors++;
                        $display("FAIL b2b_bcd: cycle=%0d bcd=%h, want %h", c, bcd, e);
                    end
                end
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c != 8) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles, want 8", c - last_c);
                    end
                end
                last_c = c;
            end
        end
        checks++;
        if (n_done != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d left=%0d, want 3 0", n_done, exp_q.size());
        end
        exp_q.delete();
        last_bcd = 8'h42;
    endtask

    task automatic test_ignore_busy();
        int n_done;
        n_done = 0;
        @(negedge clk);
        in = 6'd37; start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == 2) begin in = 6'd5; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (bcd !== 8'h37 || c != 6) begin
                    errors++;
                    $display("FAIL ignore_done: cycle=%0d bcd=%h, want cycle 6 bcd 37", c, bcd);
                end
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL ignore_count: dones=%0d, want 1", n_done);
        end
        last_bcd = 8'h37;
    endtask

    task automatic test_reset_abort();
        int n_done;
        n_done = 0;
        @(negedge clk);
        in = 6'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || bcd !== 8'h00 || ovf !== 1'b0 || st !== 2'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b bcd=%h ovf=%b st=%0d, want 0 00 0 0",
                     busy, bcd, ovf, st);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_done: dones=%0d, want 0", n_done);
        end
        last_bcd = 8'h00;
        conv6(6'd21, 8'h21);
    endtask

    task automatic conv8(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
        @(negedge clk);
        in_8 = v; start_8 = 1'b1;
        @(negedge clk);
        start_8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (k < 9) begin
                if (busy_8 !== 1'b1 || done_8 !== 1'b0) begin
                    errors++;
                    $display("FAIL w8_busy in=%0d cycle=%0d: busy=%b done=%b, want 1 0",
                             v, k, busy_8, done_8);
                end
            end else begin
                if (done_8 !== 1'b1 || bcd_8 !== exp_bcd || ovf_8 !== exp_ovf) begin
                    errors++;
                    $display("FAIL w8_done in=%0d: done=%b bcd=%h ovf=%b, want 1 %h %b",
                             v, done_8, bcd_8, ovf_8, exp_bcd, exp_ovf);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wide();
        conv8(8'd200, 8'h99, 1'b1);
        conv8(8'd99,  8'h99, 1'b0);
        conv8(8'd100, 8'h99, 1'b1);
        conv8(8'd58,  8'h58, 1'b0);
    endtask

    task automatic test_width1();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_1 = (i == 0) ? 1'b1 : 1'b0; start_1 = 1'b1;
            @(negedge clk);
            start_1 = 1'b0;
            checks++;
            if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_busy i=%0d: busy=%b done=%b, want 1 0", i, busy_1, done_1);
            end
            @(negedge clk);
            checks++;
            if (done_1 !== 1'b1 || bcd_1 !== ((i == 0) ? 8'h01 : 8'h00) || ovf_1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_done i=%0d: done=%b bcd=%h ovf=%b, want 1 %h 0",
                         i, done_1, bcd_1, ovf_1, (i == 0) ? 8'h01 : 8'h00);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in = '0;
        start_8 = 1'b0; in_8 = '0; start_1 = 1'b0; in_1 = '0;
        last_bcd = 8'h00;
        test_reset();
        test_convert();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_wide();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
